pc_sequencer: RTL and testbench

- Controls the program counter and instruction-memory fetch handshake for the single-issue MIPS core.
- Replaces free-running PC+4 stepping. Owns the PC register.
- Issues fetch requests and waits for memory acknowledge.
- Applies stall, branch and jump redirects, and flags fetch timeouts.
- Sits between the control unit / branch-resolution logic and the instruction memory.

---
 rtl/pc_sequencer_pkg.sv | 24 ++
 rtl/pc_next_calc.sv | 31 +++
 rtl/pc_sequencer.sv | 107 ++++++++++
 tb/tb_pc_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared types and constants for the PC sequencer
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    SEQ = 2'd0,
    BR  = 2'd1,
    JMP = 2'd2
  } next_sel_t;

  localparam int PC_STEP = 4;

  // jump outranks a taken branch, which outranks sequential stepping
  function automatic next_sel_t pick_sel(input logic jump, input logic branch_taken);
    return jump ? JMP : branch_taken ? BR : SEQ;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC target and PC+4 computation
module pc_next_calc
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic [7:0]      branch_offset,
  input  logic [PC_W-1:0] jump_target,
  input  logic            jump,
  input  logic            branch_taken,
  output logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc_plus4
);

  next_sel_t              sel;
  logic signed [PC_W-1:0] off_ext;
  logic [PC_W-1:0]        br_target;
  logic [PC_W-1:0]        jmp_target;

  // all arithmetic wraps modulo 2^PC_W; jump targets are forced word-aligned
  always_comb begin
    sel        = pick_sel(jump, branch_taken);
    off_ext    = PC_W'($signed(branch_offset));
    pc_plus4   = pc + PC_W'(PC_STEP);
    br_target  = pc_plus4 + PC_W'(off_ext <<< 2);
    jmp_target = jump_target & ~PC_W'(3);
    target     = sel == JMP ? jmp_target : sel == BR ? br_target : pc_plus4;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter owner and instruction-fetch handshake FSM
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [7:0]      branch_offset,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            imem_ack,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            instr_valid,
  output logic            fetch_error
);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic            pend_v_q, pend_v_d;
  logic [3:0]      wait_q, wait_d;
  logic [PC_W-1:0] target;
  logic            redirect;

  assign redirect = jump | branch_taken;

  pc_next_calc #(.PC_W(PC_W)) u_next (
    .pc           (pc_q),
    .branch_offset(branch_offset),
    .jump_target  (jump_target),
    .jump         (jump),
    .branch_taken (branch_taken),
    .target       (target),
    .pc_plus4     (pc_plus4)
  );

  // state, PC, pending redirect and wait counter registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      wait_q   <= wait_d;
    end
  end

  // next state: a fresh redirect beats a stored one, and either discards the acked data
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    wait_d   = wait_q;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
        wait_d  = '0;
      end
      FETCH: begin
        if (imem_ack) begin
          wait_d   = '0;
          pend_v_d = 1'b0;
          pc_d     = redirect ? target : pend_v_q ? pend_q : pc_q;
          state_d  = (redirect || pend_v_q) ? FETCH : VALID;
        end else begin
          wait_d   = wait_q + 4'd1;
          pend_d   = redirect ? target : pend_q;
          pend_v_d = redirect | pend_v_q;
          state_d  = wait_q == 4'(MAX_WAIT - 1) ? FAULT : FETCH;
        end
      end
      VALID: begin
        if (!stall) begin
          pc_d    = target;
          state_d = FETCH;
          wait_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // outputs decode purely from the current state
  always_comb begin
    imem_req    = state_q == FETCH;
    instr_valid = state_q == VALID;
    fetch_error = state_q == FAULT;
    imem_addr   = pc_q;
    pc          = pc_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized run against a reference model
module tb_pc_sequencer;

  localparam logic [7:0] RESET_PC = 8'h00;
  localparam int         MAX_WAIT = 4;
  localparam int M_BOOT = 0, M_FETCH = 1, M_VALID = 2, M_FAULT = 3;

  logic       CLK = 1'b0, RST_N = 1'b0;
  logic       stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, imem_ack = 1'b0;
  logic [7:0] branch_offset = '0, jump_target = '0;
  logic       imem_req, instr_valid, fetch_error;
  logic [7:0] imem_addr, pc, pc_plus4;

  int vectors = 0, miscompares = 0;

  int         m_mode = M_BOOT;
  int         m_wait = 0;
  logic [7:0] m_pc = RESET_PC, m_pend = '0;
  bit         m_pend_v = 0;

  pc_sequencer #(.PC_W(8), .RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_ack     (imem_ack),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr_valid  (instr_valid),
    .fetch_error  (fetch_error)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] next_target(input logic [7:0] p);
    if (jump) return jump_target & 8'hFC;
    if (branch_taken) return 8'(int'(p) + 4 + 4 * int'($signed(branch_offset)));
    return 8'(int'(p) + 4);
  endfunction

  function automatic logic [10:0] obs();
    return {pc, imem_req, instr_valid, fetch_error};
  endfunction

  task automatic model_step();
    logic [7:0] t;
    t = next_target(m_pc);
    if (!RST_N) begin
      m_mode = M_BOOT; m_pc = RESET_PC; m_wait = 0; m_pend_v = 0;
    end else if (m_mode == M_BOOT) begin
      m_mode = M_FETCH; m_wait = 0;
    end else if (m_mode == M_FETCH) begin
      if (imem_ack) begin
        if (jump || branch_taken) m_pc = t;
        else if (m_pend_v) m_pc = m_pend;
        else m_mode = M_VALID;
        m_pend_v = 0; m_wait = 0;
      end else begin
        if (jump || branch_taken) begin m_pend = t; m_pend_v = 1; end
        m_wait++;
        if (m_wait == MAX_WAIT) m_mode = M_FAULT;
      end
    end else if (m_mode == M_VALID && !stall) begin
      m_pc = t; m_mode = M_FETCH; m_wait = 0;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input bit st, input bit br, input logic [7:0] off,
                        input bit j, input logic [7:0] jt, input bit ack);
    stall = st; branch_taken = br; branch_offset = off;
    jump = j; jump_target = jt; imem_ack = ack;
  endtask

  task automatic test_reset();
    RST_N = 0; set_in(0, 0, 0, 0, 0, 0);
    cycle();
    vectors++;
    if (obs() !== {8'h00, 3'b000}) begin miscompares++; $display("FAIL reset: got %h want %h", obs(), {8'h00, 3'b000}); end
    RST_N = 1;
    cycle();
    vectors++;
    if (obs() !== {8'h00, 3'b100}) begin miscompares++; $display("FAIL boot_to_fetch: got %h want %h", obs(), {8'h00, 3'b100}); end
  endtask

  task automatic test_sequential();
    logic [10:0] exp;
    set_in(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      exp = {8'(4 * ((i + 1) / 2)), (i % 2 == 0) ? 3'b010 : 3'b100};
      vectors++;
      if (obs() !== exp) begin miscompares++; $display("FAIL sequential[%0d]: got %h want %h", i, obs(), exp); end
    end
  endtask

  task automatic test_stall();
    set_in(0, 0, 0, 0, 0, 1);
    cycle();
    vectors++;
    if (obs() !== {8'h10, 3'b010}) begin miscompares++; $display("FAIL stall_entry: got %h want %h", obs(), {8'h10, 3'b010}); end
    set_in(1, 1, 8'h07, 1, 8'hA4, 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if (obs() !== {8'h10, 3'b010}) begin miscompares++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs(), {8'h10, 3'b010}); end
    end
    set_in(0, 0, 0, 0, 0, 0);
    cycle();
    vectors++;
    if (obs() !== {8'h14, 3'b100}) begin miscompares++; $display("FAIL stall_release: got %h want %h", obs(), {8'h14, 3'b100}); end
  endtask

  task automatic test_branch_jump();
    set_in(0, 0, 0, 0, 0, 1); cycle();
    set_in(0, 0, 0, 1, 8'h20, 0); cycle();
    set_in(0, 0, 0, 0, 0, 1); cycle();
    vectors++;
    if (obs() !== {8'h20, 3'b010}) begin miscompares++; $display("FAIL valid_at_20: got %h want %h", obs(), {8'h20, 3'b010}); end
    set_in(0, 1, 8'hFE, 0, 0, 0); cycle();
    vectors++;
    if (obs() !== {8'h1C, 3'b100}) begin miscompares++; $display("FAIL branch_back: got %h want %h", obs(), {8'h1C, 3'b100}); end
    set_in(0, 0, 0, 0, 0, 1); cycle();
    set_in(0, 1, 8'h05, 1, 8'h43, 0); cycle();
    vectors++;
    if (obs() !== {8'h40, 3'b100}) begin miscompares++; $display("FAIL jump_over_branch: got %h want %h", obs(), {8'h40, 3'b100}); end
  endtask

  task automatic test_redirect_fetch();
    set_in(0, 0, 0, 0, 0, 1); cycle();
    set_in(0, 0, 0, 1, 8'h30, 0); cycle();
    set_in(0, 0, 0, 1, 8'h80, 0); cycle();
    vectors++;
    if (obs() !== {8'h30, 3'b100}) begin miscompares++; $display("FAIL pending_capture: got %h want %h", obs(), {8'h30, 3'b100}); end
    set_in(0, 0, 0, 0, 0, 1); cycle();
    vectors++;
    if (obs() !== {8'h80, 3'b100}) begin miscompares++; $display("FAIL pending_applied: got %h want %h", obs(), {8'h80, 3'b100}); end
    cycle();
    vectors++;
    if (obs() !== {8'h80, 3'b010}) begin miscompares++; $display("FAIL valid_at_80: got %h want %h", obs(), {8'h80, 3'b010}); end
  endtask

  task automatic test_wrap();
    set_in(0, 0, 0, 1, 8'hF8, 0); cycle();
    set_in(0, 0, 0, 0, 0, 1); cycle();
    set_in(0, 0, 0, 0, 0, 0); cycle();
    vectors++;
    if (obs() !== {8'hFC, 3'b100}) begin miscompares++; $display("FAIL step_to_fc: got %h want %h", obs(), {8'hFC, 3'b100}); end
    set_in(0, 0, 0, 0, 0, 1); cycle();
    set_in(0, 0, 0, 0, 0, 0); cycle();
    vectors++;
    if (obs() !== {8'h00, 3'b100}) begin miscompares++; $display("FAIL wrap_to_00: got %h want %h", obs(), {8'h00, 3'b100}); end
    set_in(0, 0, 0, 0, 0, 1); cycle();
    set_in(0, 1, 8'hFF, 0, 0, 0); cycle();
    vectors++;
    if (obs() !== {8'h00, 3'b100}) begin miscompares++; $display("FAIL branch_minus1: got %h want %h", obs(), {8'h00, 3'b100}); end
    set_in(0, 1, 8'h03, 0, 0, 1); cycle();
    vectors++;
    if (obs() !== {8'h10, 3'b100}) begin miscompares++; $display("FAIL redirect_with_ack: got %h want %h", obs(), {8'h10, 3'b100}); end
  endtask

  task automatic test_timeout();
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 1; i < MAX_WAIT; i++) begin
      cycle();
      vectors++;
      if (obs() !== {8'h10, 3'b100}) begin miscompares++; $display("FAIL wait[%0d]: got %h want %h", i, obs(), {8'h10, 3'b100}); end
    end
    cycle();
    vectors++;
    if (obs() !== {8'h10, 3'b001}) begin miscompares++; $display("FAIL fault_entry: got %h want %h", obs(), {8'h10, 3'b001}); end
    set_in(0, 1, 8'h02, 1, 8'h60, 1);
    for (int i = 0; i < 2; i++) begin
      cycle();
      vectors++;
      if (obs() !== {8'h10, 3'b001}) begin miscompares++; $display("FAIL fault_sticky[%0d]: got %h want %h", i, obs(), {8'h10, 3'b001}); end
    end
    RST_N = 0; cycle();
    vectors++;
    if (obs() !== {RESET_PC, 3'b000}) begin miscompares++; $display("FAIL fault_reset: got %h want %h", obs(), {RESET_PC, 3'b000}); end
    RST_N = 1;
  endtask

  task automatic test_reset_mid_fetch();
    set_in(0, 0, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 1); cycle();
    set_in(0, 0, 0, 1, 8'h44, 0); cycle();
    vectors++;
    if (obs() !== {8'h44, 3'b100}) begin miscompares++; $display("FAIL fetch_at_44: got %h want %h", obs(), {8'h44, 3'b100}); end
    set_in(0, 0, 0, 0, 0, 0); RST_N = 0; cycle();
    vectors++;
    if (obs() !== {RESET_PC, 3'b000}) begin miscompares++; $display("FAIL mid_fetch_reset: got %h want %h", obs(), {RESET_PC, 3'b000}); end
    RST_N = 1; imem_ack = 1; cycle();
    vectors++;
    if (obs() !== {RESET_PC, 3'b100}) begin miscompares++; $display("FAIL late_ack_in_boot: got %h want %h", obs(), {RESET_PC, 3'b100}); end
    cycle();
    vectors++;
    if (obs() !== {RESET_PC, 3'b010}) begin miscompares++; $display("FAIL valid_after_reset: got %h want %h", obs(), {RESET_PC, 3'b010}); end
  endtask

  task automatic test_random();
    logic [34:0] exp, got;
    for (int i = 0; i < 800; i++) begin
      RST_N         = $urandom_range(0, 99) >= 3;
      stall         = $urandom_range(0, 9) < 3;
      imem_ack      = $urandom_range(0, 9) < 6;
      branch_taken  = $urandom_range(0, 9) < 2;
      jump          = $urandom_range(0, 9) < 1;
      branch_offset = 8'($urandom);
      jump_target   = 8'($urandom);
      cycle();
      exp = {m_pc, m_pc, 8'(int'(m_pc) + 4), 8'h00, m_mode == M_FETCH, m_mode == M_VALID, m_mode == M_FAULT};
      got = {pc, imem_addr, pc_plus4, 8'h00, imem_req, instr_valid, fetch_error};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL random[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_jump();
    test_redirect_fetch();
    test_wrap();
    test_timeout();
    test_reset_mid_fetch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
